cu_fsm: RTL and testbench

Multicycle control-unit state machine for the OTTER MCU that sequences the program-counter datapath, register file, data memory and CSR file. It decides per cycle when the PC register loads its next value (`pc_write`), when the PC is forced to its reset value (`pc_rst`), and when memories, registers and CSRs are read or written. It also takes interrupts between instructions and keeps a retired-instruction count. It sits beside the combinational decoder, which supplies `pc_source` and ALU selects; `cu_fsm` supplies only the timing strobes.

---
 rtl/cu_fsm.sv | 159 +++++++++++++++
 tb/tb_cu_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_fsm.sv
// cu_fsm - multicycle control-unit sequencer for the OTTER MCU.
//
// Produces the per-cycle timing strobes for the PC register, the register
// file, the instruction/data memories and the CSR file. It also takes
// interrupts between instructions and keeps a retired-instruction count.
// The decoder alongside it supplies pc_source and the ALU selects.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   intr       in   level interrupt request (already gated by mstatus.MIE)
//   opcode     in   ir[6:0] of the current instruction
//   func3      in   ir[14:12]
//   pc_rst     out  force PC register to its reset value
//   pc_write   out  PC register load enable
//   reg_write  out  register-file write enable
//   mem_rden1  out  instruction-memory read enable
//   mem_rden2  out  data-memory read enable
//   mem_we2    out  data-memory write enable
//   csr_we     out  CSR write enable
//   int_taken  out  interrupt entry (save mepc, load mtvec)
//   mret_exec  out  mret executing (restore PC from mepc)
//   instret    out  retired-instruction counter
module cu_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic        intr,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   output logic        pc_rst,
   output logic        pc_write,
   output logic        reg_write,
   output logic        mem_rden1,
   output logic        mem_rden2,
   output logic        mem_we2,
   output logic        csr_we,
   output logic        int_taken,
   output logic        mret_exec,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_MRET   = 3'b000;
   localparam logic [2:0] F3_CSRRW  = 3'b001;

   state_t      state_q, state_d;
   logic [31:0] instret_q, instret_d;
   // High on the cycle whose pc_write retires an instruction (EXEC/WB only).
   logic        retire_s;

   // Next-state and strobe decode from the registered state and current inputs.
   always_comb begin
      state_d   = state_q;
      pc_rst    = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      mem_we2   = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      retire_s  = 1'b0;

      if (rst) begin
         // Reset wins in the same cycle: any pending write is abandoned.
         pc_rst  = 1'b1;
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_INIT: begin
               pc_rst  = 1'b1;
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               mem_rden1 = 1'b1;
               state_d   = ST_EXEC;
            end
            ST_EXEC: begin
               if (opcode == OP_LOAD) begin
                  // Loads retire in WB; intr is not looked at here.
                  mem_rden2 = 1'b1;
                  state_d   = ST_WB;
               end else begin
                  pc_write = 1'b1;
                  retire_s = 1'b1;
                  case (opcode)
                     OP_STORE:  mem_we2 = 1'b1;
                     OP_BRANCH: begin end
                     OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR:
                        reg_write = 1'b1;
                     OP_SYSTEM: begin
                        case (func3)
                           F3_CSRRW: begin
                              csr_we    = 1'b1;
                              reg_write = 1'b1;
                           end
                           F3_MRET:  mret_exec = 1'b1;
                           default:  begin end
                        endcase
                     end
                     default: begin end
                  endcase
                  state_d = intr ? ST_INTR : ST_FETCH;
               end
            end
            ST_WB: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               retire_s  = 1'b1;
               state_d   = intr ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
               // Handler entry; intr is ignored so the handler always fetches.
               int_taken = 1'b1;
               pc_write  = 1'b1;
               state_d   = ST_FETCH;
            end
            default: begin
               state_d = ST_INIT;
            end
         endcase
      end

      instret_d = retire_s ? (instret_q + 32'd1) : instret_q;
   end

   // State register and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_INIT;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm - self-checking bench for cu_fsm.
// Each cycle's stimulus and expected strobes/counter are pushed to a queue,
// then popped one per cycle: inputs are driven at the falling edge and the
// outputs sampled 1 time unit later, well away from the rising edge.
module tb_cu_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        intr = 1'b0;
   logic [6:0]  opcode = 7'b0000000;
   logic [2:0]  func3 = 3'b000;
   logic        pc_rst, pc_write, reg_write, mem_rden1, mem_rden2;
   logic        mem_we2, csr_we, int_taken, mret_exec;
   logic [31:0] instret;

   cu_fsm dut (
      .clk(clk), .rst(rst), .intr(intr), .opcode(opcode), .func3(func3),
      .pc_rst(pc_rst), .pc_write(pc_write), .reg_write(reg_write),
      .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
      .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec),
      .instret(instret)
   );

   always #5 clk = ~clk;

   // Strobe vector order: pc_rst pc_write reg_write mem_rden1 mem_rden2
   //                      mem_we2 csr_we int_taken mret_exec
   localparam logic [8:0] S_RST   = 9'b1_0000_0000;
   localparam logic [8:0] S_FETCH = 9'b0_0010_0000;
   localparam logic [8:0] S_ALU   = 9'b0_1100_0000;
   localparam logic [8:0] S_PCW   = 9'b0_1000_0000;
   localparam logic [8:0] S_LD    = 9'b0_0001_0000;
   localparam logic [8:0] S_ST    = 9'b0_1000_1000;
   localparam logic [8:0] S_CSR   = 9'b0_1100_0100;
   localparam logic [8:0] S_INT   = 9'b0_1000_0010;
   localparam logic [8:0] S_MRET  = 9'b0_1000_0001;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef struct {
      logic        r;
      logic        irq;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [8:0]  exp_s;
      logic        chk_i;
      logic [31:0] exp_i;
   } cyc_t;

   cyc_t sb_q[$];
   int   passed = 0;
   int   total  = 0;

   task automatic push(input logic r, input logic irq, input logic [6:0] op,
                       input logic [2:0] f3, input logic [8:0] s,
                       input logic ci, input logic [31:0] i);
      cyc_t c;
      c.r = r; c.irq = irq; c.op = op; c.f3 = f3;
      c.exp_s = s; c.chk_i = ci; c.exp_i = i;
      sb_q.push_back(c);
   endtask

   // One reset cycle (counter not checked) followed by the INIT cycle.
   task automatic push_reset(input logic [6:0] op);
      push(1'b1, 1'b0, op, 3'b000, S_RST, 1'b0, 32'd0);
      push(1'b0, 1'b0, op, 3'b000, S_RST, 1'b1, 32'd0);
   endtask

   task automatic drive_next(output cyc_t c, output logic [8:0] s, output logic [31:0] i);
      c = sb_q.pop_front();
      @(negedge clk);
      rst = c.r; intr = c.irq; opcode = c.op; func3 = c.f3;
      #1;
      s = {pc_rst, pc_write, reg_write, mem_rden1, mem_rden2,
           mem_we2, csr_we, int_taken, mret_exec};
      i = instret;
   endtask

   task automatic test_reset();
      cyc_t c; logic [8:0] s; logic [31:0] i; int n = 0;
      push(1'b1, 1'b0, OP_OP, 3'b000, S_RST,   1'b0, 32'd0);
      push(1'b0, 1'b0, OP_OP, 3'b000, S_RST,   1'b1, 32'd0);
      push(1'b0, 1'b0, OP_OP, 3'b000, S_FETCH, 1'b1, 32'd0);
      for (int k = 0; k < 3; k++)
         push(1'b1, 1'b0, OP_OP, 3'b000, S_RST, 1'b1, 32'd0);
      push(1'b0, 1'b0, OP_OP, 3'b000, S_RST,   1'b1, 32'd0);
      push(1'b0, 1'b0, OP_OP, 3'b000, S_FETCH, 1'b1, 32'd0);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL reset cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
   endtask

   task automatic test_alu_stream();
      cyc_t c; logic [8:0] s; logic [31:0] i; int n = 0;
      push_reset(OP_OP);
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 1'b0, OP_OP, 3'b000, S_FETCH, 1'b1, 32'(k));
         push(1'b0, 1'b0, OP_OP, 3'b000, S_ALU,   1'b1, 32'(k));
      end
      push(1'b0, 1'b0, OP_OP, 3'b000, S_FETCH, 1'b1, 32'd4);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL alu cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
   endtask

   task automatic test_load_store();
      cyc_t c; logic [8:0] s; logic [31:0] i; int n = 0;
      push_reset(OP_LOAD);
      push(1'b0, 1'b0, OP_LOAD,  3'b010, S_FETCH, 1'b1, 32'd0);
      push(1'b0, 1'b0, OP_LOAD,  3'b010, S_LD,    1'b1, 32'd0);
      push(1'b0, 1'b0, OP_LOAD,  3'b010, S_ALU,   1'b1, 32'd0);
      push(1'b0, 1'b0, OP_STORE, 3'b010, S_FETCH, 1'b1, 32'd1);
      push(1'b0, 1'b0, OP_STORE, 3'b010, S_ST,    1'b1, 32'd1);
      push(1'b0, 1'b0, OP_STORE, 3'b010, S_FETCH, 1'b1, 32'd2);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL ldst cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
   endtask

   task automatic test_interrupt();
      cyc_t c; logic [8:0] s; logic [31:0] i; int n = 0;
      push(1'b1, 1'b0, OP_IMM, 3'b000, S_RST, 1'b0, 32'd0);
      push(1'b0, 1'b1, OP_IMM, 3'b000, S_RST, 1'b1, 32'd0);
      push(1'b0, 1'b1, OP_IMM,  3'b000, S_FETCH, 1'b1, 32'd0);
      push(1'b0, 1'b1, OP_IMM,  3'b000, S_ALU,   1'b1, 32'd0);
      push(1'b0, 1'b1, OP_IMM,  3'b000, S_INT,   1'b1, 32'd1);
      push(1'b0, 1'b0, OP_LOAD, 3'b010, S_FETCH, 1'b1, 32'd1);
      push(1'b0, 1'b1, OP_LOAD, 3'b010, S_LD,    1'b1, 32'd1);
      push(1'b0, 1'b1, OP_LOAD, 3'b010, S_ALU,   1'b1, 32'd1);
      push(1'b0, 1'b0, OP_LOAD, 3'b010, S_INT,   1'b1, 32'd2);
      push(1'b0, 1'b0, OP_IMM,  3'b000, S_FETCH, 1'b1, 32'd2);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL intr cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
   endtask

   task automatic test_csr_mret();
      cyc_t c; logic [8:0] s; logic [31:0] i; int n = 0;
      push_reset(OP_SYSTEM);
      push(1'b0, 1'b0, OP_SYSTEM, 3'b001, S_FETCH, 1'b1, 32'd0);
      push(1'b0, 1'b0, OP_SYSTEM, 3'b001, S_CSR,   1'b1, 32'd0);
      push(1'b0, 1'b0, OP_SYSTEM, 3'b000, S_FETCH, 1'b1, 32'd1);
      push(1'b0, 1'b1, OP_SYSTEM, 3'b000, S_MRET,  1'b1, 32'd1);
      push(1'b0, 1'b0, OP_SYSTEM, 3'b000, S_INT,   1'b1, 32'd2);
      push(1'b0, 1'b0, OP_SYSTEM, 3'b010, S_FETCH, 1'b1, 32'd2);
      push(1'b0, 1'b0, OP_SYSTEM, 3'b010, S_PCW,   1'b1, 32'd2);
      push(1'b0, 1'b0, OP_FENCE,  3'b000, S_FETCH, 1'b1, 32'd3);
      push(1'b0, 1'b0, OP_FENCE,  3'b000, S_PCW,   1'b1, 32'd3);
      push(1'b0, 1'b0, OP_BRANCH, 3'b000, S_FETCH, 1'b1, 32'd4);
      push(1'b0, 1'b0, OP_BRANCH, 3'b000, S_PCW,   1'b1, 32'd4);
      push(1'b0, 1'b0, OP_JALR,   3'b000, S_FETCH, 1'b1, 32'd5);
      push(1'b0, 1'b0, OP_JALR,   3'b000, S_ALU,   1'b1, 32'd5);
      push(1'b0, 1'b0, OP_JALR,   3'b000, S_FETCH, 1'b1, 32'd6);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL csr cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
   endtask

   task automatic test_wrap_midreset();
      cyc_t c; logic [8:0] s; logic [31:0] i; int n = 0;
      push_reset(OP_IMM);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL wrap cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
      // Preload the counter during FETCH, hold it across the non-counting edge.
      @(posedge clk);
      #1;
      force dut.instret_q = 32'hFFFF_FFFF;
      push(1'b0, 1'b0, OP_IMM, 3'b000, S_FETCH, 1'b1, 32'hFFFF_FFFF);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL wrap cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
      @(posedge clk);
      #1;
      release dut.instret_q;
      push(1'b0, 1'b0, OP_IMM,  3'b000, S_ALU,   1'b1, 32'hFFFF_FFFF);
      push(1'b0, 1'b0, OP_LOAD, 3'b010, S_FETCH, 1'b1, 32'd0);
      push(1'b0, 1'b0, OP_LOAD, 3'b010, S_LD,    1'b1, 32'd0);
      push(1'b1, 1'b0, OP_LOAD, 3'b010, S_RST,   1'b1, 32'd0);
      push(1'b0, 1'b0, OP_LOAD, 3'b010, S_RST,   1'b1, 32'd0);
      push(1'b0, 1'b0, OP_LOAD, 3'b010, S_FETCH, 1'b1, 32'd0);
      while (sb_q.size() > 0) begin
         drive_next(c, s, i);
         total++;
         if (s !== c.exp_s || (c.chk_i && i !== c.exp_i))
            $display("FAIL wrap cyc%0d strobes=%b want %b instret=%h want %h", n, s, c.exp_s, i, c.exp_i);
         else
            passed++;
         n++;
      end
   endtask

   initial begin
      test_reset();
      test_alu_stream();
      test_load_store();
      test_interrupt();
      test_csr_mret();
      test_wrap_midreset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
